// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial add/subtract sequencer. Drives one full-adder cell,
//               LSB first, one bit per clock, with a start/done handshake.
//               Subtraction is A + ~B + 1, so cout=1 means "no borrow".
// Ports       : clk, reset (sync, active-high)
//               start, a, b, cin, sub   - request and operands (sampled in IDLE)
//               busy, done              - handshake status (Moore outputs)
//               sum, cout, overflow     - result, held until the next DONE
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int C_CW = $clog2(WIDTH);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [C_CW-1:0]  r_count;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;

    // The single full-adder cell: the only arithmetic logic between registers.
    logic w_fa_s;
    logic w_fa_co;
    assign w_fa_s  = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_fa_co = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));

    logic w_last_bit;
    assign w_last_bit = (r_count == C_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE:  if (start) w_next_state = C_SHIFT;
            C_SHIFT: if (w_last_bit) w_next_state = C_DONE;
            C_DONE:  w_next_state = C_IDLE;
            default: w_next_state = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_count <= '0;
                    end
                end
                C_SHIFT: begin
                    r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_co;
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_count <= r_count + 1'b1;
                    // On the MSB cycle r_carry is the carry into the MSB, so the
                    // visible results are loaded directly from the cell here and
                    // become valid in the DONE cycle without a separate msb-carry
                    // register.
                    if (w_last_bit) begin
                        r_sum      <= {w_fa_s, r_res[WIDTH-1:1]};
                        r_cout     <= w_fa_co;
                        r_overflow <= r_carry ^ w_fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == C_SHIFT);
    assign done     = (r_state == C_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
